// File: rtl/athena_dip_bank.sv
// athena_dip_bank: bridge-writable shadow DIP bank copied into a live bank on apply, one entry per cycle.
// Optional `DIP_BANK_LIVE_READBACK_EN: address bit above the index field reads the live bank.
module athena_dip_bank #(
  parameter int NUM_ENTRIES = 16,
  parameter int ENTRY_W     = 8,
  parameter int ADDR_LSB    = 2,
  parameter int GAME_INDEX  = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    bridge_addr,
  input  logic                           bridge_wr,
  input  logic [31:0]                    bridge_wr_data,
  input  logic                           bridge_rd,
  output logic [31:0]                    bridge_rd_data,
  output logic                           bridge_rd_data_valid,
  input  logic                           apply_req,
  output logic                           busy,
  output logic                           apply_done,
  output logic                           dips_changed,
  output logic [NUM_ENTRIES*ENTRY_W-1:0] live_entries,
  output logic [ENTRY_W-1:0]             game_sel
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;
  state_t r_state, w_next;
  logic [ENTRY_W-1:0] r_shadow [NUM_ENTRIES];
  logic [ENTRY_W-1:0] r_live [NUM_ENTRIES];
  logic [IDX_W-1:0]   r_cnt;
  logic               r_diff, r_pend;
  logic [31:0]        r_rd_data;
  logic               r_rd_valid;
  logic [IDX_W-1:0]   w_idx;
  logic               w_in_range, w_wr_ok, w_rd_live, w_last, w_start;
  logic [ENTRY_W-1:0] w_src, w_rd_val;
  logic               w_unused;
  assign w_idx      = bridge_addr[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign w_in_range = {1'b0, w_idx} < (IDX_W+1)'(NUM_ENTRIES);
`ifdef DIP_BANK_LIVE_READBACK_EN
  assign w_rd_live  = bridge_addr[ADDR_LSB+IDX_W];
`else
  assign w_rd_live  = 1'b0;
`endif
  assign w_wr_ok    = bridge_wr && w_in_range && !w_rd_live;
  assign w_last     = r_cnt == IDX_W'(NUM_ENTRIES-1);
  assign w_start    = (w_next == COPY) && (r_state != COPY);
  // A write landing on the entry being copied this cycle is forwarded so it joins this pass.
  assign w_src      = (w_wr_ok && w_idx == r_cnt) ? bridge_wr_data[ENTRY_W-1:0] : r_shadow[r_cnt];
  assign w_rd_val   = !w_in_range ? '0 : w_rd_live ? r_live[w_idx] : r_shadow[w_idx];
  assign w_unused   = ^{bridge_addr, bridge_wr_data};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (apply_req ? COPY : IDLE) :
             (r_state == COPY) ? (w_last ? DONE : COPY) :
             ((r_pend || apply_req) ? COPY : IDLE);
  end
  always_comb begin
    busy         = r_state != IDLE;
    apply_done   = r_state == DONE;
    dips_changed = (r_state == DONE) && r_diff;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
      r_cnt      <= '0;
      r_diff     <= 1'b0;
      r_pend     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_ok) r_shadow[w_idx] <= bridge_wr_data[ENTRY_W-1:0];
      r_rd_valid <= bridge_rd;
      if (bridge_rd) r_rd_data <= 32'(w_rd_val);
      r_pend <= (r_state == COPY) && (r_pend || apply_req);
      if (w_start) begin
        r_cnt  <= '0;
        r_diff <= 1'b0;
      end else if (r_state == COPY) begin
        r_live[r_cnt] <= w_src;
        r_diff        <= r_diff || (r_live[r_cnt] != w_src);
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_live
    assign live_entries[g*ENTRY_W +: ENTRY_W] = r_live[g];
  end
  assign game_sel             = r_live[GAME_INDEX];
  assign bridge_rd_data       = r_rd_data;
  assign bridge_rd_data_valid = r_rd_valid;
endmodule

// File: tb/tb_athena_dip_bank.sv
// tb_athena_dip_bank: directed-vector bench for athena_dip_bank with default parameters.
module tb_athena_dip_bank;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  bridge_addr = '0;
  logic         bridge_wr = 1'b0;
  logic [31:0]  bridge_wr_data = '0;
  logic         bridge_rd = 1'b0;
  logic [31:0]  bridge_rd_data;
  logic         bridge_rd_data_valid;
  logic         apply_req = 1'b0;
  logic         busy, apply_done, dips_changed;
  logic [127:0] live_entries;
  logic [7:0]   game_sel;
  int           n_chk = 0;
  int           n_err = 0;
  athena_dip_bank dut (
    .clk(clk), .reset(reset), .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
    .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
    .bridge_rd_data_valid(bridge_rd_data_valid), .apply_req(apply_req), .busy(busy),
    .apply_done(apply_done), .dips_changed(dips_changed), .live_entries(live_entries),
    .game_sel(game_sel)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
    tick();
    bridge_wr = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    bridge_addr = a; bridge_rd = 1'b1;
    tick();
    bridge_rd = 1'b0;
    chk({tag, "_valid"}, 64'(bridge_rd_data_valid), 64'd1);
    chk(tag, 64'(bridge_rd_data), 64'(exp));
  endtask
  task automatic apply();
    apply_req = 1'b1;
    tick();
    apply_req = 1'b0;
  endtask
  task automatic wait_done(input int start, input int exp_cyc, input logic exp_chg, input string tag);
    int c = start;
    while (!apply_done && c < start + 60) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      tick();
      c++;
    end
    chk({tag, "_done_cycle"}, 64'(c), 64'(exp_cyc));
    chk({tag, "_changed"}, 64'(dips_changed), 64'(exp_chg));
  endtask
  initial begin
    #2 reset = 1'b1;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_live", 64'(live_entries == '0), 64'd1);
    chk("rst_valid", 64'(bridge_rd_data_valid), 64'd0);
    reset = 1'b0;
    tick();
    rd(32'h0C, "rd_idx3", 32'h0);
    tick();
    chk("rd_valid_drop", 64'(bridge_rd_data_valid), 64'd0);
    wr(32'h08, 32'hFFFF_FF5A);
    rd(32'h08, "rd_idx2", 32'h5A);
    chk("live2_preapply", 64'(live_entries[23:16]), 64'h0);
    rd(32'h48, "rd_alias_idx2", 32'h5A);
    wr(32'h3C, 32'h01);
    apply();
    wait_done(1, 17, 1'b1, "apply1");
    chk("game_sel", 64'(game_sel), 64'h01);
    chk("live2_post", 64'(live_entries[23:16]), 64'h5A);
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(apply_done), 64'd0);
    apply();
    wait_done(1, 17, 1'b0, "reapply");
    tick();
    apply();
    repeat (4) tick();
    bridge_addr = 32'h00; bridge_wr_data = 32'hAA; bridge_wr = 1'b1; apply_req = 1'b1;
    tick();
    bridge_wr = 1'b0; apply_req = 1'b0;
    wait_done(6, 17, 1'b0, "pass1");
    chk("pass1_live0", 64'(live_entries[7:0]), 64'h00);
    tick();
    chk("pass2_busy", 64'(busy), 64'd1);
    wait_done(18, 34, 1'b1, "pass2");
    chk("pass2_live0", 64'(live_entries[7:0]), 64'hAA);
    tick();
    wr(32'h08, 32'h33);
    apply();
    repeat (7) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_live", 64'(live_entries == '0), 64'd1);
    chk("arst_game", 64'(game_sel), 64'h0);
    chk("arst_done", 64'(apply_done | dips_changed), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    rd(32'h08, "rd_after_rst", 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
